// File: rtl/divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed or unsigned.
// Fixed latency of DATA_WIDTH+1 edges from the start edge, with divide-by-zero and overflow handling.
module divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic [1:0]            o_dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  // Handshake: i_start is sampled only in IDLE; o_done pulses one cycle with
  // results valid, and o_busy covers every cycle from the start edge to FIX.
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  dvd_raw_q;
  logic          sign_dvd_q;
  logic          sign_dvs_q;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  quotient_q;
  logic [W-1:0]  remainder_q;

  logic [W:0]    shifted;
  logic [W+1:0]  trial;
  logic [W-1:0]  dvd_abs;
  logic [W-1:0]  dvs_abs;
  logic [W-1:0]  quotient_d;
  logic [W-1:0]  remainder_d;
  logic          div_zero;
  logic          overflow;

  always_comb begin
    shifted  = {rem_q[W-1:0], quo_q[W-1]};
    trial    = {1'b0, shifted} - {2'b00, dvs_q};
    dvd_abs  = (i_signed && i_dividend[W-1]) ? -i_dividend : i_dividend;
    dvs_abs  = (i_signed && i_divisor[W-1])  ? -i_divisor  : i_divisor;
    div_zero = (dvs_q == '0);
    // A magnitude of 1 with the sign set is a divisor of -1.
    overflow = sign_dvs_q && (dvs_q == ONE) && (dvd_raw_q == MIN_NEG);
    quotient_d  = (sign_dvd_q ^ sign_dvs_q) ? -quo_q : quo_q;
    remainder_d = sign_dvd_q ? -rem_q[W-1:0] : rem_q[W-1:0];
    if (div_zero) begin
      quotient_d  = '1;
      remainder_d = dvd_raw_q;
    end else if (overflow) begin
      quotient_d  = dvd_raw_q;
      remainder_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      sign_dvd_q  <= 1'b0;
      sign_dvs_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            quo_q      <= dvd_abs;
            dvs_q      <= dvs_abs;
            rem_q      <= '0;
            dvd_raw_q  <= i_dividend;
            sign_dvd_q <= i_signed & i_dividend[W-1];
            sign_dvs_q <= i_signed & i_divisor[W-1];
            cnt_q      <= CW'(W - 1);
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          rem_q <= trial[W+1] ? shifted : trial[W:0];
          quo_q <= {quo_q[W-2:0], ~trial[W+1]};
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          quotient_q  <= quotient_d;
          remainder_q <= remainder_d;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: arithmetic vectors, special cases, latency,
// busy/start handshake and mid-operation reset.
module tb_divider;
  logic        clk;
  logic        rst;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic [1:0]  o_dbg_state;

  int total;
  int bad;

  divider #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_dbg_state (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start request so it is sampled at the next rising edge (E0).
  task automatic start_op(input logic s, input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    i_start    = 1'b1;
    i_signed   = s;
    i_dividend = dvd;
    i_divisor  = dvs;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Count edges after E0 until o_done; lat = 100 means no o_done seen.
  task automatic wait_done(output int lat, output bit busy_ok, output bit overlap);
    lat     = 0;
    busy_ok = 1'b1;
    overlap = 1'b0;
    while (lat < 100) begin
      if (o_busy && o_done) overlap = 1'b1;
      if (!o_busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (o_busy && o_done) overlap = 1'b1;
      if (o_done) break;
    end
    if (lat == 100) lat = 999;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({o_busy, o_done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags busy/done=%b required 00", {o_busy, o_done});
    end
    total++;
    if (o_quotient !== 32'd0 || o_remainder !== 32'd0) begin
      bad++;
      $display("FAIL reset_results q=%h r=%h required 0 0", o_quotient, o_remainder);
    end
    total++;
    if (o_dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got %0d required 0", o_dbg_state);
    end
  endtask

  task automatic test_latency();
    int lat;
    bit busy_ok;
    bit overlap;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(lat, busy_ok, overlap);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL latency got %0d required 33", lat);
    end
    total++;
    if (!busy_ok || overlap || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_window busy_ok=%0d overlap=%0d busy=%b required 1 0 0", busy_ok, overlap, o_busy);
    end
    total++;
    if (o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
      bad++;
      $display("FAIL u100_7 q=%h r=%h required e 2", o_quotient, o_remainder);
    end
    @(posedge clk);
    #1;
    total++;
    if (o_done !== 1'b0 || o_quotient !== 32'd14) begin
      bad++;
      $display("FAIL done_pulse done=%b q=%h required 0 e", o_done, o_quotient);
    end
  endtask

  task automatic test_arith();
    logic        v_s   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] v_dvd [8] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFFFF,
                               32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
    logic [31:0] v_dvs [8] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'd2,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] v_q   [8] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h7FFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    logic [31:0] v_r   [8] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd1,
                               32'd5, 32'hFFFFFFFB, 32'd0, 32'h80000000};
    int lat;
    bit busy_ok;
    bit overlap;
    for (int i = 0; i < 8; i++) begin
      start_op(v_s[i], v_dvd[i], v_dvs[i]);
      wait_done(lat, busy_ok, overlap);
      total++;
      if (o_quotient !== v_q[i] || o_remainder !== v_r[i] || lat !== 33) begin
        bad++;
        $display("FAIL arith_%0d q=%h r=%h lat=%0d required q=%h r=%h lat=33",
                 i, o_quotient, o_remainder, lat, v_q[i], v_r[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit busy_ok;
    bit overlap;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = 32'd9;
    i_divisor  = 32'd2;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(lat, busy_ok, overlap);
    total++;
    if (o_quotient !== 32'd14 || o_remainder !== 32'd2 || lat !== 23) begin
      bad++;
      $display("FAIL start_ignored q=%h r=%h lat=%0d required e 2 23", o_quotient, o_remainder, lat);
    end
    @(posedge clk);
    #1;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored_idle busy=%b done=%b required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit busy_ok;
    bit overlap;
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(lat, busy_ok, overlap);
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'd9;
    i_divisor  = 32'd2;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b1 || o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
      bad++;
      $display("FAIL b2b_accept done=%b busy=%b q=%h r=%h required 0 1 e 2",
               o_done, o_busy, o_quotient, o_remainder);
    end
    wait_done(lat, busy_ok, overlap);
    total++;
    if (o_quotient !== 32'd4 || o_remainder !== 32'd1 || lat !== 33 || overlap) begin
      bad++;
      $display("FAIL b2b_result q=%h r=%h lat=%0d overlap=%0d required 4 1 33 0",
               o_quotient, o_remainder, lat, overlap);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    bit busy_ok;
    bit overlap;
    bit saw_done;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_quotient !== 32'd0 || o_remainder !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset busy=%b done=%b q=%h r=%h required 0 0 0 0",
               o_busy, o_done, o_quotient, o_remainder);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_done || o_busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL mid_reset_quiet activity seen after abandoned op, required none");
    end
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(lat, busy_ok, overlap);
    total++;
    if (o_quotient !== 32'd14 || o_remainder !== 32'd2 || lat !== 33 || !busy_ok) begin
      bad++;
      $display("FAIL after_reset q=%h r=%h lat=%0d busy_ok=%0d required e 2 33 1",
               o_quotient, o_remainder, lat, busy_ok);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    test_reset();
    test_latency();
    test_arith();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Multi-cycle integer divider for the bb_core ALU, the counterpart of the single-cycle combinational adder. It computes quotient and remainder of two DATA_WIDTH-bit operands, signed or unsigned, using restoring shift-subtract at one quotient bit per cycle. Start/busy/done handshake to the ALU control. Latency is fixed and independent of operand values.

## Interface
- DATA_WIDTH, default 32: operand and result width (W below).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with i_start.
- i_dividend  input  W  numerator; sampled with i_start.
- i_divisor  input  W  denominator; sampled with i_start.
- o_busy  output  1  high while an operation is in progress.
- o_done  output  1  one-cycle pulse; results valid.
- o_quotient  output  W  registered quotient.
- o_remainder  output  W  registered remainder.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if i_start=1 at an edge, latch operands and i_signed, go to CALC, o_busy=1, step counter loaded with W-1.
- Operand load: in signed mode, latch magnitudes |dividend| and |divisor| plus the two sign bits. In unsigned mode, latch raw values with signs forced 0.
- CALC, once per cycle for W cycles:
  - shift {rem, quo} left one bit; rem is W+1 bits.
  - trial = rem - divisor.
  - if trial >= 0: rem = trial, quo LSB = 1; else restore rem, LSB = 0.
  - After the counter's final step (count 0), go to FIX.
- FIX, one cycle, writes outputs:
  - Normal: quotient negated if sign bits differ; remainder negated if dividend sign set. Remainder takes the dividend's sign.
  - Divisor = 0 (any mode): o_quotient = all ones, o_remainder = original dividend.
  - Signed overflow (dividend = 0x80..0, divisor = all ones): o_quotient = dividend, o_remainder = 0.
  - Special cases are detected from latched operands and override the iterative result. Latency is unchanged.
  - Set o_done=1, o_busy=0, go to IDLE.
- i_start while busy (CALC/FIX): ignored, no effect on latched operands.
- o_quotient/o_remainder hold their values until the next FIX writes them.

## Timing
- Reset (rst=1 at an edge): state IDLE; o_busy=0, o_done=0, o_quotient=0, o_remainder=0; counter and internal registers cleared. Reset mid-operation abandons the operation with no o_done.
- i_start sampled at edge E0. o_busy rises after E0. CALC occupies edges E1..EW; FIX executes at edge E(W+1).
- After E(W+1): o_done=1, o_busy=0, and results are valid for exactly the cycle between E(W+1) and E(W+2). Total latency is W+1 edges from the start edge (33 for W=32).
- Back-to-back: i_start=1 during the o_done cycle is accepted at E(W+2). o_done falls and o_busy rises after that edge; previous results stay on the outputs until the new FIX.
- o_busy and o_done are never high together.
- rst takes priority over i_start at the same edge.

## Test plan
- Unsigned 100/7, W=32 -> o_quotient=14, o_remainder=2; o_done a single pulse exactly 33 edges after the start edge; o_busy high for the 33 cycles before it.
- Signed -100/7 -> o_quotient=0xFFFFFFF2, o_remainder=0xFFFFFFFE. Signed 100/-7 -> 0xFFFFFFF2, 2. Unsigned 0xFFFFFFFF/2 -> 0x7FFFFFFF, 1.
- Divide by zero: unsigned 5/0 -> 0xFFFFFFFF, 5; signed 0xFFFFFFFB/0 -> 0xFFFFFFFF, 0xFFFFFFFB; latency still 33.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> o_quotient=0x80000000, o_remainder=0. Same operands unsigned -> 0, 0x80000000.
- Handshake:
  - i_start pulsed with 9/2 at cycle 10 of a 100/7 run -> ignored; result 14, 2.
  - i_start with 9/2 on the o_done cycle -> accepted, result 4, 1 after a further 33 edges.
- rst asserted at CALC cycle 15 -> next cycle o_busy=0, outputs 0, no o_done. A fresh 100/7 then completes normally.
